// File: rtl/acc_ping.sv
// acc_ping: initiator for a NoC loopback tile. Sends numbered two-beat request
// packets one at a time, checks every echoed response against what was sent
// and keeps sent/ok/bad/latency statistics behind a small register window.
module acc_ping #(
  parameter int XY_SZ     = 3,
  parameter int OFFSET_SZ = 12
) (
  input  logic               clk_line,
  input  logic               clk_line_rst_low,
  input  logic [2*XY_SZ-1:0] HsrcId,
  input  logic               stream_out_TREADY,
  output logic               stream_out_TVALID,
  output logic [31:0]        stream_out_TDATA,
  output logic [3:0]         stream_out_TKEEP,
  output logic               stream_out_TLAST,
  input  logic               stream_in_TVALID,
  input  logic [31:0]        stream_in_TDATA,
  input  logic [3:0]         stream_in_TKEEP,
  input  logic               stream_in_TLAST,
  output logic               stream_in_TREADY,
  input  logic               mem_valid_axi,
  input  logic [31:0]        mem_addr_axi,
  input  logic [31:0]        mem_wdata_axi,
  input  logic               mem_wstrb_axi,
  output logic [31:0]        mem_rdata_axi
);

  localparam int IdW = 2 * XY_SZ;

  typedef enum logic [2:0] {IDLE, SEND_HDR, SEND_PLD, WAIT_RSP, DONE} state_t;

  state_t         state_q;
  logic [IdW-1:0] dest_q;
  logic [15:0]    count_q, timeout_q, sent_q, ok_q, bad_q, lat_q, seq_q, latCnt_q;
  logic [31:0]    seed_q, rspHdr_q, outData_q;
  logic           timeoutErr_q, abortPend_q, inBeat_q, outVld_q, outLast_q;

  logic [3:0]  regIdx;
  logic        wrEn, startReq, abortReq, outFire, busy;
  logic        rspDone, rspGood;
  logic [31:0] rspHdrEff, firstHdr_d, nextHdr_d, curPld_d;
  logic [15:0] seqInc_d, latInc_d;
  logic        unusedBits;

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign regIdx   = mem_addr_axi[5:2];
  assign wrEn     = mem_valid_axi & mem_wstrb_axi;
  assign startReq = wrEn && (regIdx == 4'd0) && mem_wdata_axi[0];
  assign abortReq = wrEn && (regIdx == 4'd0) && mem_wdata_axi[1];
  assign outFire  = outVld_q & stream_out_TREADY;
  assign busy     = (state_q == SEND_HDR) || (state_q == SEND_PLD) || (state_q == WAIT_RSP);

  // A single-beat response (TLAST on the first beat) uses that beat as its own header.
  assign rspDone   = stream_in_TVALID & stream_in_TLAST;
  assign rspHdrEff = inBeat_q ? rspHdr_q : stream_in_TDATA;
  assign rspGood   = (state_q == WAIT_RSP)
                   && (rspHdrEff[IdW-1:0] == HsrcId)
                   && (rspHdrEff[IdW+OFFSET_SZ +: IdW] == dest_q)
                   && (rspHdrEff[IdW +: OFFSET_SZ] == seq_q[OFFSET_SZ-1:0])
                   && (stream_in_TDATA == curPld_d);

  assign seqInc_d   = seq_q + 16'd1;
  assign latInc_d   = satInc(latCnt_q);
  assign curPld_d   = seed_q + {16'b0, seq_q};
  assign firstHdr_d = {8'h01, HsrcId, {OFFSET_SZ{1'b0}}, dest_q};
  assign nextHdr_d  = {8'h01, HsrcId, seqInc_d[OFFSET_SZ-1:0], dest_q};

  assign unusedBits = ^{stream_in_TKEEP, mem_addr_axi[31:6], mem_addr_axi[1:0],
                        rspHdrEff[31:2*IdW+OFFSET_SZ]};

  assign stream_out_TVALID = outVld_q;
  assign stream_out_TDATA  = outData_q;
  assign stream_out_TLAST  = outLast_q;
  assign stream_out_TKEEP  = 4'hF;
  assign stream_in_TREADY  = 1'b1;

  // Configuration registers written from the register window.
  always_ff @(posedge clk_line) begin
    if (!clk_line_rst_low) begin
      dest_q    <= '0;
      count_q   <= '0;
      seed_q    <= '0;
      timeout_q <= '0;
    end else if (wrEn) begin
      case (regIdx)
        4'd1: dest_q    <= mem_wdata_axi[IdW-1:0];
        4'd2: count_q   <= mem_wdata_axi[15:0];
        4'd3: seed_q    <= mem_wdata_axi;
        4'd4: timeout_q <= mem_wdata_axi[15:0];
        default: ;
      endcase
    end
  end

  // Response beat tracker: remember the first beat of a packet as its header.
  always_ff @(posedge clk_line) begin
    if (!clk_line_rst_low) begin
      inBeat_q <= 1'b0;
      rspHdr_q <= '0;
    end else if (stream_in_TVALID) begin
      if (stream_in_TLAST) begin
        inBeat_q <= 1'b0;
      end else if (!inBeat_q) begin
        rspHdr_q <= stream_in_TDATA;
        inBeat_q <= 1'b1;
      end
    end
  end

  // Ping FSM with registered stream outputs and statistics counters.
  always_ff @(posedge clk_line) begin
    if (!clk_line_rst_low) begin
      state_q      <= IDLE;
      seq_q        <= '0;
      sent_q       <= '0;
      ok_q         <= '0;
      bad_q        <= '0;
      lat_q        <= '0;
      latCnt_q     <= '0;
      timeoutErr_q <= 1'b0;
      abortPend_q  <= 1'b0;
      outVld_q     <= 1'b0;
      outData_q    <= '0;
      outLast_q    <= 1'b0;
    end else begin
      if (rspDone) begin
        if (rspGood) ok_q  <= satInc(ok_q);
        else         bad_q <= satInc(bad_q);
      end
      case (state_q)
        IDLE, DONE: begin
          if (abortReq) begin
            state_q <= IDLE;
          end else if (startReq) begin
            sent_q       <= '0;
            ok_q         <= '0;
            bad_q        <= '0;
            lat_q        <= '0;
            latCnt_q     <= '0;
            seq_q        <= '0;
            timeoutErr_q <= 1'b0;
            abortPend_q  <= 1'b0;
            if (count_q == 16'd0) begin
              state_q <= DONE;
            end else begin
              state_q   <= SEND_HDR;
              outVld_q  <= 1'b1;
              outLast_q <= 1'b0;
              outData_q <= firstHdr_d;
            end
          end
        end
        SEND_HDR: begin
          if (abortReq) abortPend_q <= 1'b1;
          if (outFire) begin
            state_q   <= SEND_PLD;
            outData_q <= curPld_d;
            outLast_q <= 1'b1;
          end
        end
        SEND_PLD: begin
          if (outFire) begin
            sent_q      <= satInc(sent_q);
            latCnt_q    <= '0;
            outVld_q    <= 1'b0;
            outLast_q   <= 1'b0;
            outData_q   <= '0;
            abortPend_q <= 1'b0;
            state_q     <= (abortPend_q || abortReq) ? IDLE : WAIT_RSP;
          end else if (abortReq) begin
            abortPend_q <= 1'b1;
          end
        end
        WAIT_RSP: begin
          latCnt_q <= latInc_d;
          if (abortReq) begin
            state_q <= IDLE;
          end else if (rspDone) begin
            lat_q <= latInc_d;
            seq_q <= seqInc_d;
            if (seqInc_d >= count_q) begin
              state_q <= DONE;
            end else begin
              state_q   <= SEND_HDR;
              outVld_q  <= 1'b1;
              outLast_q <= 1'b0;
              outData_q <= nextHdr_d;
            end
          end else if ((timeout_q != 16'd0) && (latInc_d >= timeout_q)) begin
            timeoutErr_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Register read mux, purely from the address.
  always_comb begin
    mem_rdata_axi = '0;
    case (regIdx)
      4'd1: mem_rdata_axi = {{(32-IdW){1'b0}}, dest_q};
      4'd2: mem_rdata_axi = {16'b0, count_q};
      4'd3: mem_rdata_axi = seed_q;
      4'd4: mem_rdata_axi = {16'b0, timeout_q};
      4'd5: mem_rdata_axi = {29'b0, timeoutErr_q, state_q == DONE, busy};
      4'd6: mem_rdata_axi = {16'b0, sent_q};
      4'd7: mem_rdata_axi = {16'b0, ok_q};
      4'd8: mem_rdata_axi = {16'b0, bad_q};
      4'd9: mem_rdata_axi = {16'b0, lat_q};
      default: mem_rdata_axi = '0;
    endcase
  end

endmodule

// File: tb/tb_acc_ping.sv
// tb_acc_ping: bench for acc_ping with a behavioural loopback tile, a request
// beat scoreboard and register-level result checks.
module tb_acc_ping;

  logic        clk_line = 1'b0;
  logic        clk_line_rst_low;
  logic [5:0]  HsrcId;
  logic        stream_out_TREADY;
  logic        stream_out_TVALID;
  logic [31:0] stream_out_TDATA;
  logic [3:0]  stream_out_TKEEP;
  logic        stream_out_TLAST;
  logic        stream_in_TVALID;
  logic [31:0] stream_in_TDATA;
  logic [3:0]  stream_in_TKEEP;
  logic        stream_in_TLAST;
  logic        stream_in_TREADY;
  logic        mem_valid_axi;
  logic [31:0] mem_addr_axi;
  logic [31:0] mem_wdata_axi;
  logic        mem_wstrb_axi;
  logic [31:0] mem_rdata_axi;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pldCycle = 0;
  int doneCyc = 0;

  logic [32:0] expQ[$];
  logic [31:0] reqQ[$];

  int lbDelay = 2;
  bit lbEnable = 1'b1;
  int lbCorrupt = -1;

  logic        prevVld = 1'b0;
  logic        prevRdy = 1'b0;
  logic [31:0] prevData = '0;

  acc_ping dut (
    .clk_line          (clk_line),
    .clk_line_rst_low  (clk_line_rst_low),
    .HsrcId            (HsrcId),
    .stream_out_TREADY (stream_out_TREADY),
    .stream_out_TVALID (stream_out_TVALID),
    .stream_out_TDATA  (stream_out_TDATA),
    .stream_out_TKEEP  (stream_out_TKEEP),
    .stream_out_TLAST  (stream_out_TLAST),
    .stream_in_TVALID  (stream_in_TVALID),
    .stream_in_TDATA   (stream_in_TDATA),
    .stream_in_TKEEP   (stream_in_TKEEP),
    .stream_in_TLAST   (stream_in_TLAST),
    .stream_in_TREADY  (stream_in_TREADY),
    .mem_valid_axi     (mem_valid_axi),
    .mem_addr_axi      (mem_addr_axi),
    .mem_wdata_axi     (mem_wdata_axi),
    .mem_wstrb_axi     (mem_wstrb_axi),
    .mem_rdata_axi     (mem_rdata_axi)
  );

  // Free-running clock and edge counter.
  always #5 clk_line = ~clk_line;
  always @(posedge clk_line) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Request stream monitor: scoreboard every accepted beat and check that a stalled beat is held.
  always @(negedge clk_line) begin
    logic [32:0] e;
    if (prevVld && !prevRdy)
      checkOutput("holdBeat", 64'({stream_out_TVALID, stream_out_TDATA}), 64'({1'b1, prevData}));
    if (clk_line_rst_low && stream_out_TVALID && stream_out_TREADY) begin
      checkOutput("keep", 64'(stream_out_TKEEP), 64'(4'hF));
      checkOutput("beatExpected", 64'(expQ.size() != 0), 64'(1));
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("reqBeat", 64'({stream_out_TLAST, stream_out_TDATA}), 64'(e));
      end
      reqQ.push_back(stream_out_TDATA);
      if (stream_out_TLAST) pldCycle = cyc + 1;
    end
    prevVld  = clk_line_rst_low && stream_out_TVALID;
    prevRdy  = stream_out_TREADY;
    prevData = stream_out_TDATA;
  end

  // Loopback tile: echo each request packet lbDelay cycles after its payload is accepted.
  initial begin : loopback
    logic [31:0] rh, rp;
    stream_in_TVALID = 1'b0;
    stream_in_TDATA  = '0;
    stream_in_TKEEP  = 4'h0;
    stream_in_TLAST  = 1'b0;
    forever begin
      @(posedge clk_line);
      if (reqQ.size() >= 2) begin
        rh = reqQ.pop_front();
        rp = reqQ.pop_front();
        if (lbEnable) begin
          if (int'(rh[17:6]) == lbCorrupt) rp = rp ^ 32'h1;
          repeat (lbDelay - 2) @(posedge clk_line);
          #1;
          stream_in_TVALID = 1'b1;
          stream_in_TKEEP  = 4'hF;
          stream_in_TLAST  = 1'b0;
          stream_in_TDATA  = {8'h01, rh[5:0], rh[17:6], rh[23:18]};
          @(posedge clk_line);
          #1;
          stream_in_TDATA = rp;
          stream_in_TLAST = 1'b1;
          @(posedge clk_line);
          #1;
          stream_in_TVALID = 1'b0;
          stream_in_TLAST  = 1'b0;
          stream_in_TDATA  = '0;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_line);
      #1;
    end
  endtask

  task automatic writeReg(input logic [3:0] idx, input logic [31:0] data);
    mem_addr_axi  = {26'b0, idx, 2'b00};
    mem_wdata_axi = data;
    mem_valid_axi = 1'b1;
    mem_wstrb_axi = 1'b1;
    @(posedge clk_line);
    #1;
    mem_valid_axi = 1'b0;
    mem_wstrb_axi = 1'b0;
  endtask

  task automatic readReg(input logic [3:0] idx, output logic [31:0] data);
    mem_addr_axi = {26'b0, idx, 2'b00};
    #1;
    data = mem_rdata_axi;
  endtask

  task automatic checkReg(input string tag, input logic [3:0] idx, input logic [31:0] exp);
    logic [31:0] v;
    readReg(idx, v);
    checkOutput(tag, 64'(v), 64'(exp));
  endtask

  // Program a run, queue the request beats it should produce, then start it.
  task automatic applyStimulus(input logic [5:0] dest, input logic [15:0] count,
                               input logic [31:0] seed, input logic [15:0] timeout,
                               input int nExp);
    writeReg(4'd1, {26'b0, dest});
    writeReg(4'd2, {16'b0, count});
    writeReg(4'd3, seed);
    writeReg(4'd4, {16'b0, timeout});
    for (int s = 0; s < nExp; s++) begin
      expQ.push_back({1'b0, 8'h01, HsrcId, 12'(s), dest});
      expQ.push_back({1'b1, seed + 32'(s)});
    end
    writeReg(4'd0, 32'h1);
  endtask

  task automatic waitDone(input int budget);
    logic [31:0] st;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk_line);
      #1;
      readReg(4'd5, st);
      if (st[1]) begin
        seen = 1'b1;
        doneCyc = cyc;
      end
    end
    checkOutput("doneReached", 64'(seen), 64'(1));
  endtask

  // Main sequence.
  initial begin
    HsrcId            = 6'h09;
    clk_line_rst_low  = 1'b0;
    stream_out_TREADY = 1'b1;
    mem_valid_axi     = 1'b0;
    mem_wstrb_axi     = 1'b0;
    mem_addr_axi      = '0;
    mem_wdata_axi     = '0;
    idle(3);

    checkOutput("rstTvalid", 64'(stream_out_TVALID), 64'(0));
    checkOutput("rstTdata", 64'(stream_out_TDATA), 64'(0));
    checkOutput("rstTlast", 64'(stream_out_TLAST), 64'(0));
    checkOutput("rstTready", 64'(stream_in_TREADY), 64'(1));
    checkReg("rstStatus", 4'd5, 32'h0);
    checkReg("rstSent", 4'd6, 32'h0);
    checkReg("rstSeed", 4'd3, 32'h0);
    clk_line_rst_low = 1'b1;
    idle(1);

    writeReg(4'd1, 32'hFFFF_FFD2);
    checkReg("destMask", 4'd1, 32'h12);
    writeReg(4'd10, 32'hDEAD_BEEF);
    checkReg("unmapped", 4'd10, 32'h0);
    checkReg("ctrlRead", 4'd0, 32'h0);

    $display("[TB] ideal loopback, three packets");
    applyStimulus(6'h12, 16'd3, 32'h100, 16'd0, 3);
    waitDone(200);
    checkReg("idealSent", 4'd6, 32'd3);
    checkReg("idealOk", 4'd7, 32'd3);
    checkReg("idealBad", 4'd8, 32'd0);
    checkReg("idealStatus", 4'd5, 32'h2);
    checkReg("idealLat", 4'd9, 32'd2);

    $display("[TB] second payload corrupted");
    lbCorrupt = 1;
    applyStimulus(6'h12, 16'd3, 32'hFFFF_FFFF, 16'd0, 3);
    waitDone(200);
    lbCorrupt = -1;
    checkReg("corrSent", 4'd6, 32'd3);
    checkReg("corrOk", 4'd7, 32'd2);
    checkReg("corrBad", 4'd8, 32'd1);
    checkReg("corrStatus", 4'd5, 32'h2);

    $display("[TB] stalled header, delayed loopback");
    stream_out_TREADY = 1'b0;
    lbDelay = 7;
    applyStimulus(6'h12, 16'd1, 32'h2000, 16'd0, 1);
    idle(5);
    stream_out_TREADY = 1'b1;
    waitDone(100);
    checkReg("stallLat", 4'd9, 32'd7);
    checkReg("stallOk", 4'd7, 32'd1);
    checkReg("stallSent", 4'd6, 32'd1);

    $display("[TB] timeout with no response");
    lbEnable = 1'b0;
    applyStimulus(6'h12, 16'd2, 32'h300, 16'd10, 1);
    waitDone(100);
    checkReg("toStatus", 4'd5, 32'h6);
    checkReg("toSent", 4'd6, 32'd1);
    checkOutput("toCycles", 64'(doneCyc - pldCycle), 64'(10));
    idle(2);
    lbEnable = 1'b1;

    $display("[TB] response on the timeout cycle");
    lbDelay = 5;
    applyStimulus(6'h12, 16'd1, 32'h400, 16'd5, 1);
    waitDone(100);
    checkReg("tieStatus", 4'd5, 32'h2);
    checkReg("tieOk", 4'd7, 32'd1);
    checkReg("tieLat", 4'd9, 32'd5);

    $display("[TB] abort during header, late response");
    stream_out_TREADY = 1'b0;
    lbDelay = 4;
    applyStimulus(6'h12, 16'd3, 32'h500, 16'd0, 1);
    writeReg(4'd0, 32'h2);
    stream_out_TREADY = 1'b1;
    idle(3);
    checkReg("abortIdle", 4'd5, 32'h0);
    checkReg("abortSent", 4'd6, 32'd1);
    idle(10);
    checkReg("lateBad", 4'd8, 32'd1);
    checkReg("lateOk", 4'd7, 32'd0);
    checkReg("lateStatus", 4'd5, 32'h0);

    $display("[TB] zero count start");
    applyStimulus(6'h12, 16'd0, 32'h600, 16'd0, 0);
    checkReg("zeroStatus", 4'd5, 32'h2);
    checkReg("zeroSent", 4'd6, 32'd0);
    checkReg("zeroBad", 4'd8, 32'd0);
    writeReg(4'd0, 32'h2);
    checkReg("abortDone", 4'd5, 32'h0);

    $display("[TB] reset in the middle of a packet");
    stream_out_TREADY = 1'b0;
    applyStimulus(6'h12, 16'd1, 32'h700, 16'd0, 0);
    idle(2);
    checkReg("preRstBusy", 4'd5, 32'h1);
    clk_line_rst_low = 1'b0;
    idle(1);
    checkOutput("midRstTvalid", 64'(stream_out_TVALID), 64'(0));
    clk_line_rst_low = 1'b1;
    stream_out_TREADY = 1'b1;
    idle(5);
    checkOutput("postRstTvalid", 64'(stream_out_TVALID), 64'(0));
    checkReg("postRstStatus", 4'd5, 32'h0);
    checkReg("postRstCount", 4'd2, 32'h0);

    checkOutput("queueEmpty", 64'(expQ.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound in case the design never settles.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
